// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_pkg
//  Description : Shared widths, saturation limits and sample types for the
//                FIR datapath and its receive-side requantizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    localparam int DIN_W   = 4;     // filter input / requantized sample width
    localparam int DOUT_W  = 10;    // filter output sample width
    localparam int SAT_MAX = 7;     // largest value representable in DIN_W
    localparam int SAT_MIN = -8;    // smallest value representable in DIN_W

    typedef logic signed [DIN_W-1:0]  din_t;
    typedef logic signed [DOUT_W-1:0] dout_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sync_fifo
//  Description : Generic single-clock FIFO with registered occupancy.
//                Head entry is presented combinationally from storage; a write
//                while full is accepted only when a read frees a slot the same
//                cycle, and a read while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [LVL_W-1:0] lvl_t;

    localparam lvl_t C_FULL_LVL = lvl_t'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    ptr_t             r_wr_ptr;
    ptr_t             r_rd_ptr;
    lvl_t             r_level;
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty   = (r_level == '0);
    assign full    = (r_level == C_FULL_LVL);
    assign level   = r_level;
    assign rd_data = r_mem[r_rd_ptr];

    // Qualify requests so the FIFO stays consistent regardless of the caller.
    assign w_do_rd = rd_en & ~empty;
    assign w_do_wr = wr_en & (~full | w_do_rd);

    // Storage: no reset needed, the head is only meaningful when not empty.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        end
    end

    // Occupancy: simultaneous read and write leaves the level unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= '0;
        end else begin
            case ({w_do_wr, w_do_rd})
                2'b10:   r_level <= r_level + lvl_t'(1);
                2'b01:   r_level <= r_level - lvl_t'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule : fir_sync_fifo
`default_nettype wire

// File: rtl/fir_requant_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : fir_requant_fifo
//  Description : Receive side of the FIR output stream. Rounds each 10-bit
//                sample to the 4-bit domain (round-half-up, saturating),
//                buffers it in a small FIFO and hands it to a valid/ready
//                consumer. Reports occupancy, a sticky overflow flag and a
//                saturating count of samples dropped while full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fir_requant_fifo
    import fir_pkg::*;
#(
    parameter int SHIFT = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DOUT_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DIN_W-1:0]  out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr,
    output logic [CNT_W-1:0]         drop_cnt
);

    // One extra bit so adding the rounding constant can never overflow.
    typedef logic signed [DOUT_W:0] ext_t;
    typedef logic [CNT_W-1:0]       cnt_t;

    localparam ext_t C_ROUND   = ext_t'(1 << (SHIFT - 1));
    localparam ext_t C_QMAX    = ext_t'(SAT_MAX);
    localparam ext_t C_QMIN    = ext_t'(SAT_MIN);
    localparam cnt_t C_CNT_MAX = '1;

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;
    ext_t             w_t;
    ext_t             w_q;
    din_t             w_sat;
    logic [DIN_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_rd;
    logic             w_wr;
    logic             w_drop;
    logic             r_ovf;
    cnt_t             r_drop_cnt;

    // Reset asserts immediately and releases two edges after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Requantize: add half an LSB, arithmetic shift, clamp to the 4-bit range.
    always_comb begin
        w_t = ext_t'(in_data) + C_ROUND;
        w_q = w_t >>> SHIFT;
        if (w_q > C_QMAX) begin
            w_sat = din_t'(SAT_MAX);
        end else if (w_q < C_QMIN) begin
            w_sat = din_t'(SAT_MIN);
        end else begin
            w_sat = din_t'(w_q);
        end
    end

    // Handshake decode; a read frees the slot a full-FIFO write needs.
    assign w_rd   = ~w_empty & out_ready;
    assign w_wr   = in_valid & (~w_full | w_rd);
    assign w_drop = in_valid & w_full & ~w_rd;

    fir_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DIN_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (w_rst_n),
        .wr_en   (w_wr),
        .wr_data (w_sat),
        .rd_en   (w_rd),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .level   (level)
    );

    // out_valid depends only on registered occupancy, never on inputs.
    assign out_valid = ~w_empty;
    assign out_data  = w_empty ? din_t'(0) : din_t'(w_head);

    // Overflow tracking: a drop in the clear cycle wins and restarts at one.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (ovf_clr) begin
                r_drop_cnt <= cnt_t'(1);
            end else if (r_drop_cnt != C_CNT_MAX) begin
                r_drop_cnt <= r_drop_cnt + cnt_t'(1);
            end
        end else if (ovf_clr) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule : fir_requant_fifo
`default_nettype wire

// File: doc/fir_requant_fifo.md
# fir_requant_fifo

Receive side of the FIR filter's 10-bit signed output stream. It rounds each valid sample back to the 4-bit signed sample domain (round-half-up, saturating), buffers the results in a small synchronous FIFO, and presents them to a downstream consumer through a valid/ready handshake. It also reports FIFO occupancy and counts samples dropped on overflow.

## Interface
Parameters:
- SHIFT, 4, arithmetic right shift applied before saturation; legal range 1..6
- DEPTH, 4, FIFO entries; power of two, 2..16
- CNT_W, 8, width of the drop counter

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; one clock domain only
- in_valid  in  1  in_data carries a sample this cycle
- in_data  in  10  signed sample from the filter
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts out_data this cycle
- out_data  out  4  signed requantized sample at the FIFO head
- level  out  $clog2(DEPTH)+1  number of entries currently held
- ovf  out  1  sticky overflow flag
- ovf_clr  in  1  synchronous clear of ovf and drop_cnt
- drop_cnt  out  CNT_W  count of dropped samples; saturates at all-ones

## Operation
- Requantize (combinational, no added latency):
  - t = in_data + 2^(SHIFT-1), computed in 11-bit signed.
  - q = t >>> SHIFT (arithmetic shift).
  - Saturate q to [-8, +7].
- Write: occurs when in_valid=1 and the FIFO is not full, or when it is full and a read happens in the same cycle.
- Read: occurs when out_valid=1 and out_ready=1.
- Drop: in_valid=1, FIFO full, no read that cycle.
  - The sample is discarded and ovf is set.
  - drop_cnt increments, saturating at 2^CNT_W-1.
- Simultaneous read and write:
  - Full: write the new sample, pop the head; level unchanged.
  - Empty: only the write takes effect; the new sample is visible the next cycle, with no fall-through.
- Read while empty: ignored.
- Pointers wrap modulo DEPTH. level tracks occupancy exactly, 0..DEPTH.
- out_data = head entry when out_valid=1; driven 4'sd0 when empty.
- ovf_clr:
  - Clears ovf and drop_cnt at the next edge.
  - If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- Reset (asserted low, asynchronous):
  - Pointers, level, ovf and drop_cnt go to 0.
  - out_valid=0, out_data=0.
  - Contents in flight are lost. Reset mid-stream requires no recovery beyond this.

## Timing
- Latency is 1 cycle: a sample accepted at edge N appears on out_data / out_valid after edge N. The consumer may take it in cycle N+1.
- Throughput is one sample per cycle in and out while not full/empty.
- level, ovf and drop_cnt are registered; they update at the same edge as the triggering event.
- Reset deassertion is synchronized internally with a 2-flop release, so the first write is accepted no earlier than the 2nd edge after rst rises.
- No combinational path from in_valid or out_ready to out_valid.

## Structure
- Shared package fir_pkg:
  - DIN_W=4, DOUT_W=10.
  - SAT_MAX=7, SAT_MIN=-8.
  - Signed sample typedefs for both widths, so the filter and this block agree on widths.
- Sub-module fir_sync_fifo:
  - Generic storage and pointers (parameters DEPTH, WIDTH).
  - Outputs: full, empty, level.
- Requantizer, drop/overflow logic and reset synchronizer live in the top.

## Test plan
- Rounding/saturation with out_ready=1, SHIFT=4:
  - in_data 98, 8, 7, -8, -9 → out_data 6, 1, 0, 0, -1 (-1 arrives one cycle after its input).
  - in_data -112 → -7.
  - in_data 511 → 7.
  - in_data -512 → -8.
- Fill/drain:
  - out_ready=0, 4 valid samples → level=4, ovf=0.
  - 2 more samples → ovf=1, drop_cnt=2, level=4.
  - out_ready=1 → first 4 samples emerge in order, then out_valid=0, out_data=0.
- Full with simultaneous read/write, 10 cycles in_valid=1 and out_ready=1 → level stays 4, no drops, output order preserved.
- Drop-counter saturation:
  - CNT_W=3, 10 drops → drop_cnt=7.
  - ovf_clr pulse → drop_cnt=0, ovf=0.
  - ovf_clr in the same cycle as a drop → drop_cnt=1, ovf=1.
- Reset mid-operation:
  - level=3, assert rst asynchronously mid-cycle → out_valid=0, level=0 immediately.
  - After release, first accepted sample appears as the sole entry.
- Random soak: 10k cycles, random in_valid/out_ready against a scoreboard model of the rounding and drop rules.
